// File: rtl/exec_stage.sv
// exec_stage: execute stage of the pipeline. Computes ALU, branch-compare and
// load/store address results and registers them into the stage-output register
// that feeds mem_access. Optional iterative RV32M multiply/divide unit, built only
// when the EXEC_MULDIV_EN macro is defined; it stalls the front end while busy.
module exec_stage #(
    parameter int XLEN     = 32,
    parameter int MD_ITERS = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            flush,
    input  logic            valid_i,
    input  logic [XLEN-1:0] PC_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            use_imm,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            is_muldiv,
    input  logic            wb_i,
    output logic            stall_o,
    output logic            mem_en,
    output logic            LOAD,
    output logic [XLEN-1:0] address,
    output logic [2:0]      mem_para,
    output logic [XLEN-1:0] value,
    output logic [XLEN-1:0] alu_res,
    output logic            write_back,
    output logic            branch_flag,
    output logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] PC_o,
    output logic [4:0]      rd_o
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                           OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_PASSB = 4'd10;

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_val;
    logic            br_taken;
    logic            normal_issue;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    // Only 32-bit datapaths with a non-zero iteration count are meaningful; other
    // configurations elaborate this empty marker block so they stand out in the hierarchy.
    if (XLEN != 32 || MD_ITERS < 1) begin : g_unsupported_cfg
    end

    assign op_b = use_imm ? imm : rs2_val;

    // Integer ALU; shift amounts come from the low five bits of operand B.
    always_comb begin
        alu_val = '0;
        case (alu_op)
            OP_ADD:   alu_val = rs1_val + op_b;
            OP_SUB:   alu_val = rs1_val - op_b;
            OP_SLL:   alu_val = rs1_val << op_b[4:0];
            OP_SLT:   alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
            OP_SLTU:  alu_val = {{(XLEN-1){1'b0}}, rs1_val < op_b};
            OP_XOR:   alu_val = rs1_val ^ op_b;
            OP_SRL:   alu_val = rs1_val >> op_b[4:0];
            OP_SRA:   alu_val = $unsigned($signed(rs1_val) >>> op_b[4:0]);
            OP_OR:    alu_val = rs1_val | op_b;
            OP_AND:   alu_val = rs1_val & op_b;
            OP_PASSB: alu_val = op_b;
            default:  alu_val = '0;
        endcase
    end

    // Branch condition always compares the two register operands.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    localparam int CNT_W = $clog2(MD_ITERS + 1);

    md_state_t        md_state_reg, md_state_next;
    logic [CNT_W-1:0] md_cnt_reg;
    logic [XLEN-1:0]  md_hi_reg, md_lo_reg, md_b_reg, md_hi_next, md_lo_next;
    logic [2:0]       md_op_reg;
    logic             md_neg_p_reg, md_neg_q_reg, md_neg_r_reg;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag, div_diff;
    logic [XLEN:0]    mul_sum, div_shift;
    logic             div_ge;
    logic             last_iter;

    // Signed operands are reduced to magnitudes; the sign is reapplied on the result.
    // MUL keeps raw operands since the low product word is sign-agnostic.
    always_comb begin
        a_neg = (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) && rs1_val[XLEN-1];
        b_neg = (funct3 inside {3'b001, 3'b100, 3'b110}) && rs2_val[XLEN-1];
        a_mag = a_neg ? -rs1_val : rs1_val;
        b_mag = b_neg ? -rs2_val : rs2_val;
    end

    assign last_iter = (md_cnt_reg == CNT_W'(MD_ITERS - 1));

    // MD FSM next state and stall; flush overrides everything and returns to IDLE.
    always_comb begin
        md_state_next = md_state_reg;
        stall_o       = 1'b0;
        md_done       = 1'b0;
        case (md_state_reg)
            MD_IDLE: begin
                if (valid_i && is_muldiv) begin
                    md_state_next = MD_BUSY;
                    stall_o       = 1'b1;
                end
            end
            MD_BUSY: begin
                stall_o = 1'b1;
                if (last_iter) md_state_next = MD_DONE;
            end
            MD_DONE: begin
                md_done       = 1'b1;
                md_state_next = MD_IDLE;
            end
            default: md_state_next = MD_IDLE;
        endcase
        if (flush) begin
            md_state_next = MD_IDLE;
            stall_o       = 1'b0;
            md_done       = 1'b0;
        end
    end

    // One iteration: shift-add multiply (product in {hi,lo}) or restoring divide
    // (remainder in hi, quotient shifted into lo).
    always_comb begin
        mul_sum   = {1'b0, md_hi_reg} + (md_lo_reg[0] ? {1'b0, md_b_reg} : {(XLEN+1){1'b0}});
        div_shift = {md_hi_reg, md_lo_reg[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, md_b_reg});
        div_diff  = div_shift[XLEN-1:0] - md_b_reg;
        if (md_op_reg[2]) begin
            md_hi_next = div_ge ? div_diff : div_shift[XLEN-1:0];
            md_lo_next = {md_lo_reg[XLEN-2:0], div_ge};
        end else begin
            md_hi_next = mul_sum[XLEN:1];
            md_lo_next = {mul_sum[0], md_lo_reg[XLEN-1:1]};
        end
    end

    // Final sign fix-up; the high word of a negated 64-bit product is ~hi plus a carry from lo.
    always_comb begin
        case (md_op_reg)
            3'b000:                md_result = md_lo_reg;
            3'b001, 3'b010, 3'b011:
                md_result = md_neg_p_reg ? (~md_hi_reg + {{(XLEN-1){1'b0}}, (md_lo_reg == '0)})
                                         : md_hi_reg;
            3'b100, 3'b101:        md_result = md_neg_q_reg ? -md_lo_reg : md_lo_reg;
            default:               md_result = md_neg_r_reg ? -md_hi_reg : md_hi_reg;
        endcase
    end

    // MD state and datapath registers: load operands on start, iterate while busy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            md_state_reg <= MD_IDLE;
            md_cnt_reg   <= '0;
            md_hi_reg    <= '0;
            md_lo_reg    <= '0;
            md_b_reg     <= '0;
            md_op_reg    <= '0;
            md_neg_p_reg <= 1'b0;
            md_neg_q_reg <= 1'b0;
            md_neg_r_reg <= 1'b0;
        end else begin
            md_state_reg <= md_state_next;
            if (md_state_reg == MD_IDLE && valid_i && is_muldiv && !flush) begin
                md_cnt_reg   <= '0;
                md_hi_reg    <= '0;
                md_lo_reg    <= a_mag;
                md_b_reg     <= b_mag;
                md_op_reg    <= funct3;
                md_neg_p_reg <= a_neg ^ b_neg;
                md_neg_q_reg <= (a_neg ^ b_neg) && (rs2_val != '0);
                md_neg_r_reg <= a_neg;
            end else if (md_state_reg == MD_BUSY) begin
                md_cnt_reg <= md_cnt_reg + 1'b1;
                md_hi_reg  <= md_hi_next;
                md_lo_reg  <= md_lo_next;
            end
        end
    end

    assign normal_issue = valid_i && !is_muldiv && !flush && (md_state_reg == MD_IDLE);
`else
    assign stall_o      = 1'b0;
    assign md_done      = 1'b0;
    assign md_result    = '0;
    assign normal_issue = valid_i && !is_muldiv && !flush;
`endif

    // Stage-output register feeding mem_access; anything not issuing becomes a bubble.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_en        <= 1'b0;
            LOAD          <= 1'b0;
            address       <= '0;
            mem_para      <= '0;
            value         <= '0;
            alu_res       <= '0;
            write_back    <= 1'b0;
            branch_flag   <= 1'b0;
            branch_offset <= '0;
            PC_o          <= '0;
            rd_o          <= '0;
        end else begin
            address       <= rs1_val + imm;
            value         <= rs2_val;
            mem_para      <= funct3;
            branch_offset <= imm;
            PC_o          <= PC_i;
            if (normal_issue) begin
                mem_en      <= is_load || is_store;
                LOAD        <= (is_load || is_store) ? is_load : 1'b1;
                write_back  <= wb_i;
                branch_flag <= is_branch;
                rd_o        <= rd_i;
                alu_res     <= is_branch ? {{(XLEN-1){1'b0}}, br_taken} : alu_val;
            end else if (md_done) begin
                mem_en      <= 1'b0;
                LOAD        <= 1'b1;
                write_back  <= wb_i;
                branch_flag <= 1'b0;
                rd_o        <= rd_i;
                alu_res     <= md_result;
            end else begin
                mem_en      <= 1'b0;
                LOAD        <= 1'b1;
                write_back  <= 1'b0;
                branch_flag <= 1'b0;
                rd_o        <= '0;
                alu_res     <= '0;
            end
        end
    end
endmodule
